toggle_pulse_decoder: RTL and testbench

TOGGLE_PULSE_DECODER -- requirements
Module: toggle_pulse_decoder

---
 rtl/toggle_pulse_decoder.sv | 104 ++++++++++
 tb/tb_toggle_pulse_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/toggle_pulse_decoder.sv
// Toggle-encoded event decoder: each level change on tog_in becomes one pulse and one pending event.
// Optional two-flop input synchronizer enabled by defining TOGGLE_DEC_SYNC_EN.
module toggle_pulse_decoder #(
  parameter int PEND_W = 4,
  parameter int TOT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tog_in,
  output logic              pulse_out,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [PEND_W-1:0] pend_cnt,
  output logic [TOT_W-1:0]  total_cnt,
  output logic              ovf
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

`ifdef TOGGLE_DEC_SYNC_EN
  logic s1_q, s1_d;
`endif
  logic              s2_q, s2_d;
  logic              prev_q, prev_d;
  logic              pulse_q, pulse_d;
  logic [1:0]        state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [TOT_W-1:0]  total_q, total_d;
  logic              ovf_q, ovf_d;
  logic              det;
  logic              accept;

  assign evt_valid = (state_q != ST_IDLE);
  assign pulse_out = pulse_q;
  assign pend_cnt  = pend_q;
  assign total_cnt = total_q;
  assign ovf       = ovf_q;

  always_comb begin
`ifdef TOGGLE_DEC_SYNC_EN
    s1_d = tog_in;
    s2_d = s1_q;
`else
    s2_d = tog_in;
`endif
    prev_d  = s2_q;
    det     = s2_q ^ prev_q;
    pulse_d = det;
    accept  = evt_valid & evt_ready;
    total_d = total_q + {{(TOT_W-1){1'b0}}, det};
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        // evt_ready is meaningless here since evt_valid is low
        if (det) pend_d = {{(PEND_W-1){1'b0}}, 1'b1};
      end
      ST_ACTIVE: begin
        if (det && !accept)      pend_d = pend_q + 1'b1;
        else if (accept && !det) pend_d = pend_q - 1'b1;
      end
      ST_FULL: begin
        // A det that coincides with an accept replaces the consumed slot, so nothing is lost
        if (det && !accept)      ovf_d  = 1'b1;
        else if (accept && !det) pend_d = pend_q - 1'b1;
      end
      default: pend_d = '0;
    endcase
    if (pend_d == '0)            state_d = ST_IDLE;
    else if (pend_d == PEND_MAX) state_d = ST_FULL;
    else                         state_d = ST_ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef TOGGLE_DEC_SYNC_EN
      s1_q    <= 1'b0;
`endif
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      state_q <= ST_IDLE;
      pend_q  <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
`ifdef TOGGLE_DEC_SYNC_EN
      s1_q    <= s1_d;
`endif
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// Self-checking bench for toggle_pulse_decoder: directed scenarios plus randomized traffic
// compared every cycle against an event-level reference model.
module tb_toggle_pulse_decoder;

`ifdef TOGGLE_DEC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int PEND_MAX = 15;
  localparam int TOT_MOD  = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tog_in = 1'b0;
  logic       evt_ready = 1'b0;
  logic       pulse_out;
  logic       evt_valid;
  logic [3:0] pend_cnt;
  logic [7:0] total_cnt;
  logic       ovf;

  toggle_pulse_decoder #(.PEND_W(4), .TOT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .tog_in    (tog_in),
    .pulse_out (pulse_out),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .pend_cnt  (pend_cnt),
    .total_cnt (total_cnt),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: events are level changes of the sampled input, delivered LAT-1 edges later
  bit m_pipe[$];
  bit m_last;
  int m_pend;
  int m_total;
  bit m_ovf;
  bit m_pulse;
  bit t;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit tg, input bit rd, input bit rs);
    bit mat;
    bit acc;
    if (rs) begin
      m_pipe.delete();
      for (int i = 0; i < LAT - 1; i++) m_pipe.push_back(1'b0);
      m_last = 1'b0; m_pend = 0; m_total = 0; m_ovf = 1'b0; m_pulse = 1'b0;
    end else begin
      acc = (m_pend != 0) && rd;
      mat = m_pipe.pop_front();
      m_pipe.push_back(tg ^ m_last);
      m_last = tg;
      if (mat && !acc) begin
        if (m_pend == PEND_MAX) m_ovf = 1'b1;
        else m_pend++;
      end else if (acc && !mat) begin
        m_pend--;
      end
      if (mat) m_total = (m_total + 1) % TOT_MOD;
      m_pulse = mat;
    end
  endtask

  task automatic tick(input bit tg, input bit rd, input bit rs);
    tog_in = tg; evt_ready = rd; rst = rs;
    @(posedge clk);
    model_step(tg, rd, rs);
    #1;
    chk("pulse_out", int'(pulse_out), int'(m_pulse));
    chk("evt_valid", int'(evt_valid), int'(m_pend != 0));
    chk("pend_cnt",  int'(pend_cnt),  m_pend);
    chk("total_cnt", int'(total_cnt), m_total);
    chk("ovf",       int'(ovf),       int'(m_ovf));
  endtask

  task automatic do_reset();
    t = 1'b0;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic togs(input int n, input bit rd);
    for (int i = 0; i < n; i++) begin
      t = ~t;
      tick(t, rd, 1'b0);
    end
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) tick(t, rd, 1'b0);
  endtask

  initial begin
    m_pipe.delete();
    for (int i = 0; i < LAT - 1; i++) m_pipe.push_back(1'b0);
    m_last = 0; m_pend = 0; m_total = 0; m_ovf = 0; m_pulse = 0; t = 0;

    do_reset();
    chk("rst_pend", int'(pend_cnt), 0);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_total", int'(total_cnt), 0);

    // Single toggle: pulse exactly LAT edges after the change
    togs(1, 1'b0);
    idle(LAT - 2, 1'b0);
    chk("single_pre", int'(pulse_out), 0);
    idle(1, 1'b0);
    chk("single_pulse", int'(pulse_out), 1);
    chk("single_pend", int'(pend_cnt), 1);
    chk("single_total", int'(total_cnt), 1);
    chk("single_valid", int'(evt_valid), 1);
    idle(1, 1'b0);
    chk("single_width", int'(pulse_out), 0);

    // Back-to-back toggles, then drain three and one extra
    togs(2, 1'b0);
    idle(LAT, 1'b0);
    chk("b2b_pend", int'(pend_cnt), 3);
    idle(1, 1'b1); chk("drain_2", int'(pend_cnt), 2);
    idle(1, 1'b1); chk("drain_1", int'(pend_cnt), 1);
    idle(1, 1'b1); chk("drain_0", int'(pend_cnt), 0);
    chk("drain_valid", int'(evt_valid), 0);
    idle(1, 1'b1); chk("drain_extra", int'(pend_cnt), 0);

    // Saturation
    do_reset();
    togs(16, 1'b0);
    idle(LAT, 1'b0);
    chk("sat_pend", int'(pend_cnt), 15);
    chk("sat_ovf", int'(ovf), 1);
    chk("sat_total", int'(total_cnt), 16);
    idle(16, 1'b1);
    chk("sat_drained", int'(pend_cnt), 0);
    chk("sat_ovf_sticky", int'(ovf), 1);

    // FULL with det and accept on the same edge
    do_reset();
    togs(15, 1'b0);
    idle(LAT, 1'b0);
    chk("full_pend", int'(pend_cnt), 15);
    togs(1, 1'b0);
    idle(LAT - 2, 1'b0);
    idle(1, 1'b1);
    chk("simul_pulse", int'(pulse_out), 1);
    chk("simul_pend", int'(pend_cnt), 15);
    chk("simul_ovf", int'(ovf), 0);

    // Total counter wrap
    do_reset();
    togs(256, 1'b1);
    idle(LAT, 1'b1);
    chk("wrap_total", int'(total_cnt), 0);

    // Mid-operation reset discards the in-flight toggle
    do_reset();
    togs(5, 1'b0);
    idle(LAT, 1'b0);
    chk("mid_pend", int'(pend_cnt), 5);
    t = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    chk("mid_rst_pulse", int'(pulse_out), 0);
    chk("mid_rst_pend", int'(pend_cnt), 0);
    chk("mid_rst_total", int'(total_cnt), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    chk("mid_rst_valid", int'(evt_valid), 0);
    idle(LAT + 1, 1'b0);
    chk("mid_after_total", int'(total_cnt), 0);

    // tog_in high across reset release counts as one event
    t = 1'b1;
    tick(1'b1, 1'b0, 1'b1);
    idle(LAT, 1'b0);
    chk("rel_pulse", int'(pulse_out), 1);
    chk("rel_total", int'(total_cnt), 1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bit rs;
      rs = ($urandom_range(0, 99) == 0);
      t = $urandom_range(0, 1);
      tick(t, 1'($urandom_range(0, 1)), rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
